// File: rtl/fir_mc.sv
// Multi-channel time-shared FIR: one MAC per tap cycle, per-channel delay lines,
// runtime coefficients, round-half-up, output saturation and overrun pulses.
module fir_mc #(
    parameter int DW       = 20,
    parameter int CW       = 16,
    parameter int TAPS     = 16,
    parameter int CHANNELS = 2,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int TW      = $clog2(TAPS)
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic signed [DW-1:0] in,
    input  logic [CHW-1:0]       ch_in,
    input  logic                 input_ready,
    input  logic                 coef_we,
    input  logic [TW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic signed [DW-1:0] out,
    output logic [CHW-1:0]       ch_out,
    output logic                 output_ready,
    output logic                 busy,
    output logic                 overrun
);

    localparam int AW = DW + CW + TW;
    localparam int PW = DW + CW;
    localparam logic [CHW:0] CH_LIM = (CHW+1)'(CHANNELS);
    localparam logic [TW-1:0] T_LAST = TW'(TAPS - 1);
    localparam logic signed [CW-1:0] C_DEF = CW'((1 << (CW - 1)) / TAPS);
    localparam logic signed [AW-1:0] RND = AW'(1) <<< (CW - 2);
    localparam logic signed [AW-1:0] MAXV = (AW'(1) <<< (DW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ROUND,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic ir_q, ir_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [TW-1:0] rd_q, rd_d;
    logic [TW-1:0] k_q, k_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] rnd_q, rnd_d;
    logic signed [DW-1:0] out_q, out_d;
    logic [CHW-1:0] ch_out_q, ch_out_d;
    logic ordy_q, ordy_d;
    logic ovr_q, ovr_d;
    logic [TW-1:0] wp_q [CHANNELS];
    logic [TW-1:0] wp_d [CHANNELS];
    logic signed [DW-1:0] buf_q [CHANNELS][TAPS];
    logic signed [DW-1:0] buf_d [CHANNELS][TAPS];
    logic signed [CW-1:0] coef_q [TAPS];
    logic signed [CW-1:0] coef_d [TAPS];

    logic strobe;
    logic ch_ok;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] shifted;
    logic signed [DW-1:0] sat;

    assign out          = out_q;
    assign ch_out       = ch_out_q;
    assign output_ready = ordy_q;
    assign overrun      = ovr_q;
    assign busy         = (state_q != S_IDLE);

    always_comb begin
        strobe  = input_ready & ~ir_q;
        ch_ok   = {1'b0, ch_in} < CH_LIM;
        prod    = PW'(buf_q[ch_q][rd_q]) * PW'(coef_q[k_q]);
        sum     = acc_q + RND;
        shifted = sum >>> (CW - 1);
        if (shifted > MAXV) begin
            sat = MAXV[DW-1:0];
        end else if (shifted < MINV) begin
            sat = MINV[DW-1:0];
        end else begin
            sat = shifted[DW-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = input_ready;
        ch_d     = ch_q;
        rd_d     = rd_q;
        k_d      = k_q;
        acc_d    = acc_q;
        rnd_d    = rnd_q;
        out_d    = out_q;
        ch_out_d = ch_out_q;
        ordy_d   = 1'b0;
        ovr_d    = 1'b0;
        wp_d     = wp_q;
        buf_d    = buf_q;
        coef_d   = coef_q;

        // Write precedes the strobe's MAC, so a same-cycle sample sees it
        if (coef_we && !busy) begin
            coef_d[coef_addr] = coef_data;
        end

        unique case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    if (ch_ok) begin
                        buf_d[ch_in][wp_q[ch_in]] = in;
                        ch_d    = ch_in;
                        rd_d    = wp_q[ch_in];
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = S_MAC;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            S_MAC: begin
                ovr_d = strobe;
                acc_d = acc_q + AW'(prod);
                rd_d  = (rd_q == '0) ? T_LAST : rd_q - TW'(1);
                k_d   = k_q + TW'(1);
                if (k_q == T_LAST) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                ovr_d   = strobe;
                rnd_d   = sat;
                state_d = S_DONE;
            end
            S_DONE: begin
                ovr_d       = strobe;
                out_d       = rnd_q;
                ch_out_d    = ch_q;
                ordy_d      = 1'b1;
                wp_d[ch_q]  = (wp_q[ch_q] == T_LAST) ? '0 : wp_q[ch_q] + TW'(1);
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ir_q     <= 1'b0;
            ch_q     <= '0;
            rd_q     <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            rnd_q    <= '0;
            out_q    <= '0;
            ch_out_q <= '0;
            ordy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                wp_q[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    buf_q[c][t] <= '0;
                end
            end
            for (int t = 0; t < TAPS; t++) begin
                coef_q[t] <= C_DEF;
            end
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ch_q     <= ch_d;
            rd_q     <= rd_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            rnd_q    <= rnd_d;
            out_q    <= out_d;
            ch_out_q <= ch_out_d;
            ordy_q   <= ordy_d;
            ovr_q    <= ovr_d;
            wp_q     <= wp_d;
            buf_q    <= buf_d;
            coef_q   <= coef_d;
        end
    end

endmodule
